// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: WIDTH-bit adder built from one shared external 4-bit
// carry-lookahead adder, stepped one nibble per cycle, LSB nibble first.
// The inter-nibble carry is registered between cycles.
// Optional feature macro: CLA_SEQ_SUB_EN adds subtraction (A - B) via op_sub.
module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   op_cin,
    input  logic                   op_sub,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_ovf,
    output logic                   busy,
    output logic [3:0]             cla_a,
    output logic [3:0]             cla_b,
    output logic                   cla_cin,
    input  logic [3:0]             cla_s,
    input  logic                   cla_cout
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic               msb_cin;

`ifdef CLA_SEQ_SUB_EN
    logic               sub_reg;
`else
    logic               unused_op_sub;
    assign unused_op_sub = op_sub;
`endif

    // Handshake and status flags come straight from the registered state
    assign op_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    // Select the current nibble of each latched operand (B inverted for subtract)
    always_comb begin
        a_nib = 4'd0;
        b_nib = 4'd0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IDX_W'(k)) begin
                a_nib = a_reg[4*k +: 4];
                b_nib = b_reg[4*k +: 4];
            end
        end
`ifdef CLA_SEQ_SUB_EN
        b_nib = b_nib ^ {4{sub_reg}};
`endif
    end

    // The CLA only sees live operands while a nibble is being processed
    assign cla_a   = (state == RUN) ? a_nib : 4'd0;
    assign cla_b   = (state == RUN) ? b_nib : 4'd0;
    assign cla_cin = (state == RUN) ? carry : 1'b0;

    // Carry into the sign bit, recovered from the MSB nibble's top bit slice
    assign msb_cin = a_nib[3] ^ b_nib[3] ^ cla_s[3];

    // Sequencer FSM: accept operands, step nibbles, present result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_ovf  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        idx   <= '0;
`ifdef CLA_SEQ_SUB_EN
                        sub_reg <= op_sub;
                        carry   <= op_sub ? 1'b1 : op_cin;
`else
                        carry   <= op_cin;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (idx == IDX_W'(k)) begin
                            res_sum[4*k +: 4] <= cla_s;
                        end
                    end
                    carry <= cla_cout;
                    if (idx == LAST) begin
                        res_cout <= cla_cout;
                        res_ovf  <= cla_cout ^ msb_cin;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Testbench for cla_nibble_sequencer with a behavioural 4-bit CLA attached.
module tb_cla_nibble_sequencer;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         op_sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ovf;
    logic         busy;
    logic [3:0]   cla_a;
    logic [3:0]   cla_b;
    logic         cla_cin;
    logic [3:0]   cla_s;
    logic         cla_cout;
    logic [4:0]   cla_full;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Behavioural 4-bit adder standing in for the shared CLA
    assign cla_full = {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_cin};
    assign cla_s    = cla_full[3:0];
    assign cla_cout = cla_full[4];

    cla_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
        .busy(busy),
        .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
        .cla_s(cla_s), .cla_cout(cla_cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, overflow from operand/result signs
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   s;
        logic         ovf;
        bb = b;
        c  = cin;
`ifdef CLA_SEQ_SUB_EN
        if (sub) begin
            bb = ~b;
            c  = 1'b1;
        end
`else
        if (sub) c = cin;
`endif
        s   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, s};
    endfunction

    // One transaction; called at #1 after a rising edge. stall = DONE cycles with res_ready low.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int stall,
                          output logic [W-1:0] sum, output logic cout, output logic ovf,
                          output logic [N-1:0] cin_trace);
        int n;
        int w;
        w = 0;
        while (!op_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("op_ready_before_accept", op_ready, 1);
        op_a = a; op_b = b; op_cin = cin; op_sub = sub; op_valid = 1'b1;
        res_ready = (stall == 0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("busy_in_run", busy, 1);
        check("op_ready_in_run", op_ready, 0);
        n = 0;
        cin_trace = '0;
        while (!res_valid && n < 20) begin
            if (n < N) cin_trace[n] = cla_cin;
            n++;
            @(posedge clk); #1;
        end
        check("latency", n, N);
        sum = res_sum; cout = res_cout; ovf = res_ovf;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_op_ready", op_ready, 0);
            check("hold_sum", res_sum, sum);
            check("hold_cout_ovf", {res_cout, res_ovf}, {cout, ovf});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", res_valid, 0);
        check("op_ready_after", op_ready, 1);
        check("cla_idle_zero", {cla_a, cla_b, cla_cin}, 0);
    endtask

    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic [N-1:0] tr;
    logic [W+1:0] m;

    initial begin
        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`ifdef CLA_SEQ_SUB_EN
        vecs[5] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
`else
        vecs[5] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0};
`endif

        rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
        op_sub = 1'b0; res_ready = 1'b1;
        #12;
        check("rst_op_ready", op_ready, 1);
        check("rst_flags", {res_valid, busy}, 0);
        check("rst_result", {res_sum, res_cout, res_ovf}, 0);
        check("rst_cla", {cla_a, cla_b, cla_cin}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, s, co, ov, tr);
            check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), co, vecs[i].cout);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
            if (i == 1) check("vec1_cin_trace", tr, 4'b0110);
        end

        // Consumer stalls three cycles in DONE
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 3, s, co, ov, tr);
        check("stall_sum", {co, ov, s}, {2'b00, 16'h5556});

        // Randomized operations against the whole-word model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            m = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, int'($urandom_range(0, 2)), s, co, ov, tr);
            check($sformatf("rnd%0d", i), {ov, co, s}, m);
        end

        // Reset during the second RUN cycle discards the operation
        op_a = 16'hABCD; op_b = 16'h1111; op_cin = 1'b1; op_sub = 1'b0;
        op_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_flags", {res_valid, busy}, 0);
        check("abort_result", {res_sum, res_cout, res_ovf}, 0);
        check("abort_cla", {cla_a, cla_b, cla_cin}, 0);
        check("abort_op_ready", op_ready, 1);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("abort_no_valid", {res_valid, busy, op_ready}, 3'b001);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle sequencer that performs WIDTH-bit addition by driving the existing 4-bit carry-lookahead adder one nibble per cycle, LSB nibble first, and registering the inter-nibble carry. It sits between a requester (valid/ready operand channel) and a consumer (valid/ready result channel). It owns the single shared 4-bit CLA instance, which is connected combinationally through the `cla_*` ports.

## Interface
- `NIBBLES`, 4, number of 4-bit nibbles per operand, ≥1; WIDTH = 4*NIBBLES
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `op_valid`  in  1  operands offered
- `op_ready`  out  1  sequencer can accept operands
- `op_a`  in  WIDTH  operand A
- `op_b`  in  WIDTH  operand B
- `op_cin`  in  1  carry-in to LSB nibble
- `op_sub`  in  1  subtract request; used only with `CLA_SEQ_SUB_EN`
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_sum`  out  WIDTH  sum
- `res_cout`  out  1  carry out of MSB nibble
- `res_ovf`  out  1  two's-complement overflow
- `busy`  out  1  high in RUN or DONE
- `cla_a`, `cla_b`  out  4  nibble operands to CLA
- `cla_cin`  out  1  CLA carry-in
- `cla_s`  in  4  CLA sum, combinational
- `cla_cout`  in  1  CLA carry-out, combinational

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `op_ready`=1. On `op_valid && op_ready`, latch `op_a`, `op_b`, and the initial carry (`op_cin`, or 1 for subtract). Clear the nibble index. Go to RUN.
- RUN: drive the current nibble. `cla_a` = A[4i+3:4i]. `cla_b` = B nibble, inverted when subtracting. `cla_cin` = carry register. Each edge:
  - store `cla_s` into `res_sum` nibble i;
  - carry register ← `cla_cout`;
  - i++.
- RUN, last nibble (i = NIBBLES-1):
  - `res_cout` ← `cla_cout`;
  - `res_ovf` ← `cla_cout` XOR carry into bit WIDTH-1. The carry into bit WIDTH-1 is `cla_a[3]` ^ `cla_b[3]` ^ `cla_s[3]`.
  - Go to DONE.
- DONE: `res_valid`=1. Hold `res_sum`, `res_cout` and `res_ovf` stable until `res_ready`, then go to IDLE.
- No new operands are accepted in the cycle the result is consumed. `op_ready` rises the following cycle.
- Outside RUN, `cla_a`, `cla_b` and `cla_cin` are driven to 0.
- Index counter width is $clog2(NIBBLES), minimum 1 bit. The counter never wraps past NIBBLES-1.
- Reset, any state: state→IDLE; all datapath registers and all outputs cleared. An in-flight operation is discarded and no result is emitted.

## Timing
- Reset values:
  - `op_ready`=1 (combinational from IDLE);
  - `res_valid`=0, `res_sum`=0, `res_cout`=0, `res_ovf`=0;
  - `busy`=0;
  - `cla_a`=0, `cla_b`=0, `cla_cin`=0.
- Acceptance edge T: RUN spans cycles T+1..T+NIBBLES. `res_valid` is high from edge T+NIBBLES.
- Minimum initiation interval: NIBBLES+2 cycles (RUN, DONE, IDLE).
- `res_valid` with `res_ready` already high: 1 cycle of DONE.
- `op_ready`, `busy` and `res_valid` are decoded from registered state only. There is no combinational path from `op_valid` or `res_ready` to any output.
- NIBBLES=1: RUN lasts exactly one cycle.

## Configuration
- `CLA_SEQ_SUB_EN` defined:
  - `op_sub` is latched at acceptance;
  - when it is 1, every B nibble is inverted and the initial carry is forced to 1 (`op_cin` is ignored);
  - `res_cout`=1 means no borrow.
- Not defined: `op_sub` is ignored (treated as 0). No inversion logic is present.

## Test plan
- NIBBLES=4, 0x0000+0x0000, cin=0, `res_ready`=1 → accepted at T; `res_valid` at T+4; sum 0x0000, cout 0, ovf 0.
- 0x00FF+0x0001, cin=0 → sum 0x0100, cout 0. `cla_cin` is 1 during nibbles 1 and 2.
- 0xFFFF+0xFFFF, cin=1 → sum 0xFFFF, cout 1, ovf 0.
- 0x7FFF+0x0001 → sum 0x8000, cout 0, ovf 1. With the macro and `op_sub`=1: 0x0005-0x0003 → 0x0002, cout 1, ovf 0.
- `res_ready` held low 3 cycles in DONE → outputs stable and `op_ready`=0 throughout. After the handshake, `op_ready`=1 on the next cycle.
- `rst_n` asserted in the 2nd RUN cycle → all outputs 0 immediately. After release, `op_ready`=1 and no `res_valid` ever appears for the aborted operation.
